// File: rtl/window_pkg.sv
// Shared types and elaboration-time coefficient math for the window multiplier.
// Real arithmetic here only ever folds into constants; nothing real reaches gates.
package window_pkg;

  typedef enum logic [1:0] {
    WIN_RECT     = 2'd0,
    WIN_HANN     = 2'd1,
    WIN_HAMMING  = 2'd2,
    WIN_BLACKMAN = 2'd3
  } window_mode_t;

  localparam int DEFAULT_COEF_WIDTH = 16;
  localparam int COEF_ONE = 1 << (DEFAULT_COEF_WIDTH - 1);

  localparam real PI = 3.14159265358979323846;

  function automatic int coef_one_of(input int coef_width);
    return 1 << (coef_width - 1);
  endfunction

  // Q1.(coef_width-1) window value for index n, rounded to nearest and clamped to [0, 1.0].
  function automatic int window_coef(input int mode, input int n, input int frame_len,
                                     input int coef_width);
    real one;
    real phase;
    real w;
    real scaled;
    int  result;
    one   = real'(coef_one_of(coef_width));
    phase = 2.0 * PI * real'(n) / real'(frame_len - 1);
    case (mode)
      1:       w = 0.5 - 0.5 * $cos(phase);
      2:       w = 0.54 - 0.46 * $cos(phase);
      3:       w = 0.42 - 0.5 * $cos(phase) + 0.08 * $cos(2.0 * phase);
      default: w = 1.0;
    endcase
    scaled = w * one;
    if (scaled < 0.0) begin
      result = 0;
    end else if (scaled >= one) begin
      result = coef_one_of(coef_width);
    end else begin
      result = $rtoi(scaled + 0.5);
    end
    return result;
  endfunction

endpackage

// File: rtl/window_coef.sv
// Coefficient ROM: four windows stacked as {mode, idx}, registered read so the
// constant table maps onto block RAM.
module window_coef_rom
  import window_pkg::*;
#(
  parameter int COEF_WIDTH = 16,
  parameter int FRAME_LEN  = 4096
) (
  input  logic                          clk,
  input  logic [1:0]                    mode,
  input  logic [$clog2(FRAME_LEN)-1:0]  idx,
  output logic [COEF_WIDTH-1:0]         coef
);

  logic [COEF_WIDTH-1:0] rom [4*FRAME_LEN];

  for (genvar m = 0; m < 4; m++) begin : g_mode
    for (genvar n = 0; n < FRAME_LEN; n++) begin : g_idx
      localparam int C = window_coef(m, n, FRAME_LEN, COEF_WIDTH);
      assign rom[m*FRAME_LEN + n] = COEF_WIDTH'(C);
    end
  end

  always_ff @(posedge clk) begin
    coef <= rom[{mode, idx}];
  end

endmodule

// File: rtl/window_apply.sv
// Streaming window multiplier: frame index tracking, per-frame mode latch and a
// 3-stage register/multiply/round-saturate datapath with first/last markers.
module window_apply
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int FRAME_LEN  = 4096
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid_in,
  input  logic                         sample_first_in,
  input  logic [1:0]                   mode_in,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_valid_out,
  output logic                         sample_first_out,
  output logic                         sample_last_out
);

  localparam int IDX_WIDTH  = $clog2(FRAME_LEN);
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);
  localparam logic signed [PROD_WIDTH-1:0] ROUND_BIAS = PROD_WIDTH'(2 ** (COEF_WIDTH - 2));

  logic [IDX_WIDTH-1:0] idx;
  logic [IDX_WIDTH-1:0] use_idx;
  window_mode_t         mode_reg;
  window_mode_t         use_mode;

  logic                         s1_valid, s1_first, s1_last;
  logic signed [DATA_WIDTH-1:0] s1_sample;
  logic [COEF_WIDTH-1:0]        coef;

  logic                         s2_valid, s2_first, s2_last;
  logic signed [PROD_WIDTH-1:0] s2_product;
  logic signed [PROD_WIDTH-1:0] mul_a, mul_b;

  logic signed [PROD_WIDTH-1:0] rounded;
  logic signed [DATA_WIDTH-1:0] saturated;

  // A frame start (forced or natural wrap) is the only point a new window may be chosen.
  always_comb begin
    use_idx  = sample_first_in ? '0 : idx;
    use_mode = (use_idx == '0) ? window_mode_t'(mode_in) : mode_reg;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx      <= '0;
      mode_reg <= WIN_RECT;
    end else if (sample_valid_in) begin
      idx      <= use_idx + IDX_WIDTH'(1);
      mode_reg <= use_mode;
    end
  end

  window_coef_rom #(
    .COEF_WIDTH (COEF_WIDTH),
    .FRAME_LEN  (FRAME_LEN)
  ) u_rom (
    .clk  (clk_in),
    .mode (use_mode),
    .idx  (use_idx),
    .coef (coef)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sample <= '0;
    end else begin
      s1_valid  <= sample_valid_in;
      s1_first  <= sample_valid_in && (use_idx == '0);
      s1_last   <= sample_valid_in && (use_idx == LAST_IDX);
      s1_sample <= sample_in;
    end
  end

  // Coefficient is zero-extended so 1.0 stays positive in the signed multiply.
  always_comb begin
    mul_a = PROD_WIDTH'(s1_sample);
    mul_b = PROD_WIDTH'($signed({1'b0, coef}));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s2_valid   <= 1'b0;
      s2_first   <= 1'b0;
      s2_last    <= 1'b0;
      s2_product <= '0;
    end else begin
      s2_valid   <= s1_valid;
      s2_first   <= s1_first;
      s2_last    <= s1_last;
      s2_product <= mul_a * mul_b;
    end
  end

  always_comb begin
    rounded = (s2_product + ROUND_BIAS) >>> (COEF_WIDTH - 1);
    if ((rounded[PROD_WIDTH-1:DATA_WIDTH-1] == '0) ||
        (rounded[PROD_WIDTH-1:DATA_WIDTH-1] == '1)) begin
      saturated = rounded[DATA_WIDTH-1:0];
    end else if (rounded[PROD_WIDTH-1]) begin
      saturated = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      saturated = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_valid_out <= 1'b0;
      sample_first_out <= 1'b0;
      sample_last_out  <= 1'b0;
      sample_out       <= '0;
    end else begin
      sample_valid_out <= s2_valid;
      sample_first_out <= s2_first;
      sample_last_out  <= s2_last;
      sample_out       <= saturated;
    end
  end

endmodule

// File: tb/tb_window_apply.sv
// Scoreboard bench for window_apply with an 8-sample frame and hand-computed
// Q1.15 coefficient tables; stimulus pushes expectations, a monitor pops them.
module tb_window_apply;
  import window_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int FL = 8;

  logic                 clk = 1'b0;
  logic                 rst_in;
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid_in;
  logic                 sample_first_in;
  logic [1:0]           mode_in;
  logic signed [DW-1:0] sample_out;
  logic                 sample_valid_out;
  logic                 sample_first_out;
  logic                 sample_last_out;

  window_apply #(
    .DATA_WIDTH (DW),
    .COEF_WIDTH (CW),
    .FRAME_LEN  (FL)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_first_in  (sample_first_in),
    .mode_in          (mode_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .sample_first_out (sample_first_out),
    .sample_last_out  (sample_last_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    data;
    logic  first;
    logic  last;
    int    tol;
    int    issued;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycle = 0;
  int   m_idx = 0;
  int   m_mode = 0;

  // Rows: rect, Hann, Hamming, Blackman for N=8, scaled by 32768 and rounded by hand.
  int coef_tab [4][8] = '{
    '{32768, 32768, 32768, 32768, 32768, 32768, 32768, 32768},
    '{0, 6169, 20030, 31145, 31145, 20030, 6169, 0},
    '{2621, 8297, 21049, 31275, 31275, 21049, 8297, 2621},
    '{0, 2964, 15047, 30158, 30158, 15047, 2964, 0}
  };

  int ham_vec [8] = '{1000, -1000, 20000, -20000, 32767, -32768, 12345, -5};

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input exp_t e);
    int got;
    int diff;
    got  = int'(sample_out);
    diff = got - e.data;
    if (diff < 0) diff = -diff;
    compared++;
    if (diff > e.tol) begin
      mismatched++;
      $display("[TB] FAIL %s data: got %0d expected %0d (tol %0d)", e.tag, got, e.data, e.tol);
    end
    compared++;
    if ({sample_first_out, sample_last_out} !== {e.first, e.last}) begin
      mismatched++;
      $display("[TB] FAIL %s flags: got first=%0b last=%0b expected first=%0b last=%0b",
               e.tag, sample_first_out, sample_last_out, e.first, e.last);
    end
    compared++;
    if (cycle - e.issued != 3) begin
      mismatched++;
      $display("[TB] FAIL %s latency: got %0d expected 3", e.tag, cycle - e.issued);
    end
  endtask

  always @(negedge clk) begin
    if (sample_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got sample_out=%0d with no expected entry", sample_out);
      end else begin
        checkOutput(sb.pop_front());
      end
    end
  end

  task automatic applyStimulus(input int value, input logic first, input int mode, input string tag);
    int     eff;
    longint prod;
    exp_t   e;
    eff = first ? 0 : m_idx;
    if (eff == 0) m_mode = mode;
    prod = longint'(value) * longint'(coef_tab[m_mode][eff]) + 64'sd16384;
    prod = prod >>> 15;
    if (prod > 32767) prod = 32767;
    else if (prod < -32768) prod = -32768;
    e.data   = int'(prod);
    e.first  = (eff == 0);
    e.last   = (eff == FL - 1);
    e.tol    = (m_mode == 0) ? 0 : 1;
    e.issued = cycle;
    e.tag    = $sformatf("%s[%0d]", tag, eff);
    sb.push_back(e);
    m_idx = (eff + 1) % FL;
    sample_in       = DW'(value);
    sample_valid_in = 1'b1;
    sample_first_in = first;
    mode_in         = mode[1:0];
    @(posedge clk);
    #1;
    sample_valid_in = 1'b0;
    sample_first_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    compared++;
    if ({sample_valid_out, sample_first_out, sample_last_out} !== 3'b000 || sample_out !== '0) begin
      mismatched++;
      $display("[TB] FAIL %s: got valid=%0b first=%0b last=%0b out=%0d expected all zero",
               tag, sample_valid_out, sample_first_out, sample_last_out, sample_out);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_in          = 1'b1;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    sample_first_in = 1'b0;
    mode_in         = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(negedge clk);
    checkReset("reset_state");
    idle(1);

    $display("[TB] rect ramp");
    for (int v = -32768; v <= 32767; v += 128) begin
      applyStimulus(v, (v == -32768), int'(WIN_RECT), "rect");
    end
    applyStimulus(32767, 1'b0, int'(WIN_RECT), "rect_max");

    $display("[TB] Hann constant frame");
    applyStimulus(16384, 1'b1, int'(WIN_HANN), "hann");
    for (int i = 1; i < FL; i++) applyStimulus(16384, 1'b0, int'(WIN_HANN), "hann");

    $display("[TB] Hamming continuous then gapped");
    for (int i = 0; i < FL; i++) applyStimulus(ham_vec[i], 1'b0, int'(WIN_HAMMING), "ham_cont");
    for (int i = 0; i < FL; i++) begin
      applyStimulus(ham_vec[i], 1'b0, int'(WIN_HAMMING), "ham_gap");
      idle(1);
    end

    $display("[TB] mode change mid-frame");
    for (int i = 0; i < FL; i++) begin
      applyStimulus(30000, 1'b0, (i < 3) ? int'(WIN_HANN) : int'(WIN_BLACKMAN), "switch");
    end
    for (int i = 0; i < FL; i++) applyStimulus(30000, 1'b0, int'(WIN_BLACKMAN), "black");

    $display("[TB] forced frame start at index 5");
    for (int i = 0; i < 5; i++) applyStimulus(25000, 1'b0, int'(WIN_HANN), "pre_sync");
    applyStimulus(25000, 1'b1, int'(WIN_HANN), "resync");
    for (int i = 1; i < FL; i++) applyStimulus(25000, 1'b0, int'(WIN_HANN), "post_sync");

    $display("[TB] reset with samples in flight");
    for (int i = 0; i < 4; i++) applyStimulus(8000, 1'b0, int'(WIN_HANN), "flight");
    rst_in          = 1'b1;
    sample_in       = 16'sd777;
    sample_valid_in = 1'b1;
    mode_in         = 2'd1;
    @(posedge clk);
    #1;
    sb.delete();
    rst_in          = 1'b0;
    sample_valid_in = 1'b0;
    m_idx           = 0;
    m_mode          = 0;
    @(negedge clk);
    checkReset("reset_mid_frame");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compared++;
      if (sample_valid_out !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL post_reset_quiet: got valid=%0b expected 0", sample_valid_out);
      end
    end
    @(posedge clk);
    #1;
    applyStimulus(1234, 1'b0, int'(WIN_RECT), "after_reset");
    applyStimulus(-1234, 1'b0, int'(WIN_RECT), "after_reset");

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d outstanding expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/window_apply.md
# window_apply

Streaming, parametrised window-function multiplier for the audio transcription front end. It sits between the sample capture/decimation stage and the FFT. It multiplies each incoming signed sample by a per-index coefficient from a selectable window: rectangular, Hann, Hamming or Blackman. It tracks its position within a frame, so the FFT receives framed, windowed data with first/last markers.

## Interface
Parameters:
- DATA_WIDTH, 16, signed sample width in and out
- COEF_WIDTH, 16, unsigned coefficient width, format Q1.(COEF_WIDTH-1), so 1.0 = 2^(COEF_WIDTH-1)
- FRAME_LEN, 4096, samples per frame; must be a power of two, ≥ 8

Ports (one clock; reset is synchronous and active-high):
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- sample_in  input  DATA_WIDTH  signed sample
- sample_valid_in  input  1  sample_in is valid this cycle
- sample_first_in  input  1  qualified by valid; forces this sample to frame index 0
- mode_in  input  2  window select: 0 rect, 1 Hann, 2 Hamming, 3 Blackman
- sample_out  output  DATA_WIDTH  signed windowed sample
- sample_valid_out  output  1  sample_out valid
- sample_first_out  output  1  sample_out is frame index 0
- sample_last_out  output  1  sample_out is frame index FRAME_LEN-1

## Operation
- No backpressure. One sample is accepted in every cycle where sample_valid_in=1. Gaps (valid low) are allowed and do not advance the index.
- Index counter idx, width log2(FRAME_LEN):
  - Each valid sample uses the current idx, then idx advances by 1.
  - FRAME_LEN-1 wraps to 0.
  - If sample_first_in=1 with valid, that sample uses idx 0 and the counter becomes 1. This resynchronises mid-frame, with no error flag.
- Mode register:
  - Loaded from mode_in only when a valid sample uses idx 0.
  - mode_in changes mid-frame are ignored until the next frame start, so a frame never mixes windows.
- Coefficients, n = idx, N = FRAME_LEN, rounded to nearest at elaboration:
  - rect: w = 1.0
  - Hann: w = 0.5 − 0.5cos(2πn/(N−1))
  - Hamming: w = 0.54 − 0.46cos(2πn/(N−1))
  - Blackman: w = 0.42 − 0.5cos(2πn/(N−1)) + 0.08cos(4πn/(N−1))
  - Negative results clamp to 0; results above 1.0 clamp to 2^(COEF_WIDTH-1).
- Arithmetic:
  - Product = signed sample × zero-extended coefficient, held in DATA_WIDTH+COEF_WIDTH+1 bits.
  - Add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1 (round half up).
  - Saturate to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1].
- Rect mode with coefficient exactly 1.0 yields sample_out = sample_in bit-exact.

## Timing
- Fixed latency of 3 cycles from sample_valid_in to sample_valid_out; sample_first_out and sample_last_out travel with the data.
  - Stage 1: register sample, index, mode; ROM read.
  - Stage 2: multiply.
  - Stage 3: round and saturate.
- Throughput is 1 sample per cycle. The pipeline advances every cycle; valid bits propagate as a shift chain.
- Reset, effective on the clock edge with rst_in=1:
  - idx=0, mode register=0 (rect)
  - all pipeline valid bits 0
  - sample_out=0, sample_valid_out=0, sample_first_out=0, sample_last_out=0
- Reset mid-frame discards all in-flight samples: no valid output appears in the 3 cycles following reset.
- Inputs are ignored while rst_in=1.
- sample_first_in on a cycle where idx is already 0 behaves identically to normal wrap.
- A frame start and a mode_in change in the same cycle: the new mode applies to that sample.

## Structure
- Package window_pkg holds:
  - enum window_mode_t (WIN_RECT, WIN_HANN, WIN_HAMMING, WIN_BLACKMAN)
  - the Q-format helper constant COEF_ONE = 2^(COEF_WIDTH-1)
  - the elaboration-time coefficient function (real math, constant-folded only, never synthesised as real)
- Sub-module window_coef_rom (params COEF_WIDTH, FRAME_LEN):
  - four FRAME_LEN-deep tables, synchronous read, 1-cycle latency
  - address is {mode, idx}
  - maps to block RAM
- window_apply instantiates one window_coef_rom plus the counter, mode register and 3-stage datapath.

## Test plan
- Rect mode, DATA_WIDTH=16, ramp input −32768…32767 continuous valid → sample_out equals input exactly, 3 cycles later.
- Hann, FRAME_LEN=8, constant input 16384 for 8 samples → outputs match the model to ±1 LSB; index 0 and 7 give 0; first/last flags asserted on indices 0 and 7 only.
- Hamming, valid toggling 1-0-1-0 across a full frame → same output values as the continuous-valid run; the index does not advance on gaps.
- mode_in switched from Hann to Blackman at index 3 → the remainder of that frame stays Hann; the next frame (index 0) is Blackman.
- sample_first_in asserted at index 5 → that sample is windowed with w[0] and sample_first_out is set; the following sample uses w[1].
- rst_in pulsed for 1 cycle mid-frame with 2 samples in flight → no valid output for 3 cycles; the next valid sample is index 0, rect mode.
